// File: rtl/alu8_sched_pkg.sv
// Shared types for the round-robin two-requester ALU scheduler.
// Opcode and FSM state encodings live here so the top and the bench agree on them.
package alu8_sched_pkg;

    typedef enum logic [1:0] {
        OP_ADD    = 2'b00,
        OP_SUB    = 2'b01,
        OP_ADDSUB = 2'b10,
        OP_RSVD   = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        PASS1 = 2'b01,
        PASS2 = 2'b10,
        RESP  = 2'b11
    } state_e;

endpackage

// File: rtl/alu8_addc.sv
// Single shared W-bit adder with carry-in; every scheduler operation goes through it.
module alu8_addc #(
    parameter int W = 8
) (
    input  logic [W-1:0] I0,
    input  logic [W-1:0] I1,
    input  logic         CIN,
    output logic [W-1:0] O,
    output logic         COUT
);

    assign {COUT, O} = {1'b0, I0} + {1'b0, I1} + {{W{1'b0}}, CIN};

endmodule

// File: rtl/alu8_rr_sched.sv
// Two-requester ALU front end: round-robin grant, one or two passes through a shared
// adder, then a held response until the consumer takes it.
module alu8_rr_sched
    import alu8_sched_pkg::*;
#(
    parameter int W = 8
) (
    input  logic         CLK,
    input  logic         ASYNCRESETN,
    input  logic [1:0]   req_valid,
    output logic [1:0]   req_ready,
    input  logic [1:0]   req0_op,
    input  logic [W-1:0] req0_a,
    input  logic [W-1:0] req0_b,
    input  logic [W-1:0] req0_c,
    input  logic [1:0]   req1_op,
    input  logic [W-1:0] req1_a,
    input  logic [W-1:0] req1_b,
    input  logic [W-1:0] req1_c,
    output logic         rsp_valid,
    input  logic         rsp_ready,
    output logic         rsp_id,
    output logic [W-1:0] rsp_data,
    output logic         rsp_cout,
    output logic         rsp_err,
    output logic         busy
);

    state_e       state_q;
    logic         last_grant_q;
    op_e          op_q;
    logic [W-1:0] a_q;
    logic [W-1:0] b_q;
    logic [W-1:0] c_q;
    logic         id_q;
    logic [W-1:0] acc_q;
    logic [W-1:0] rsp_data_q;
    logic         rsp_id_q;
    logic         rsp_cout_q;
    logic         rsp_err_q;

    logic         gnt_any;
    logic         gnt_id;
    logic         accept;
    logic [1:0]   sel_op;
    logic [W-1:0] sel_a;
    logic [W-1:0] sel_b;
    logic [W-1:0] sel_c;

    logic [W-1:0] add_x;
    logic [W-1:0] add_y;
    logic         add_cin;
    logic [W-1:0] add_sum;
    logic         add_cout;

    // On a tie the requester that did not win last time gets the grant.
    always_comb begin
        gnt_any = |req_valid;
        gnt_id  = 1'b0;
        if (req_valid == 2'b11) begin
            gnt_id = ~last_grant_q;
        end else begin
            gnt_id = req_valid[1];
        end
    end

    always_comb begin
        req_ready = 2'b00;
        if (ASYNCRESETN && (state_q == IDLE) && gnt_any) begin
            req_ready = gnt_id ? 2'b10 : 2'b01;
        end
    end

    assign accept = |(req_valid & req_ready);

    always_comb begin
        sel_op = req0_op;
        sel_a  = req0_a;
        sel_b  = req0_b;
        sel_c  = req0_c;
        if (gnt_id) begin
            sel_op = req1_op;
            sel_a  = req1_a;
            sel_b  = req1_b;
            sel_c  = req1_c;
        end
    end

    // Subtraction is P + ~Q + 1 through the same adder.
    always_comb begin
        add_x   = '0;
        add_y   = '0;
        add_cin = 1'b0;
        case (state_q)
            PASS1: begin
                add_x   = a_q;
                add_y   = (op_q == OP_SUB) ? ~b_q : b_q;
                add_cin = (op_q == OP_SUB);
            end
            PASS2: begin
                add_x   = acc_q;
                add_y   = ~c_q;
                add_cin = 1'b1;
            end
            default: begin
                add_x   = '0;
                add_y   = '0;
                add_cin = 1'b0;
            end
        endcase
    end

    alu8_addc #(
        .W(W)
    ) u_addc (
        .I0  (add_x),
        .I1  (add_y),
        .CIN (add_cin),
        .O   (add_sum),
        .COUT(add_cout)
    );

    always_ff @(posedge CLK or negedge ASYNCRESETN) begin
        if (!ASYNCRESETN) begin
            state_q      <= IDLE;
            last_grant_q <= 1'b1;
            op_q         <= OP_ADD;
            a_q          <= '0;
            b_q          <= '0;
            c_q          <= '0;
            id_q         <= 1'b0;
            acc_q        <= '0;
            rsp_data_q   <= '0;
            rsp_id_q     <= 1'b0;
            rsp_cout_q   <= 1'b0;
            rsp_err_q    <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        op_q         <= op_e'(sel_op);
                        a_q          <= sel_a;
                        b_q          <= sel_b;
                        c_q          <= sel_c;
                        id_q         <= gnt_id;
                        last_grant_q <= gnt_id;
                        state_q      <= PASS1;
                    end
                end
                PASS1: begin
                    rsp_id_q <= id_q;
                    if (op_q == OP_RSVD) begin
                        rsp_data_q <= '0;
                        rsp_cout_q <= 1'b0;
                        rsp_err_q  <= 1'b1;
                        state_q    <= RESP;
                    end else if (op_q == OP_ADDSUB) begin
                        acc_q   <= add_sum;
                        state_q <= PASS2;
                    end else begin
                        acc_q      <= add_sum;
                        rsp_data_q <= add_sum;
                        rsp_cout_q <= add_cout;
                        rsp_err_q  <= 1'b0;
                        state_q    <= RESP;
                    end
                end
                PASS2: begin
                    rsp_data_q <= add_sum;
                    rsp_cout_q <= add_cout;
                    rsp_err_q  <= 1'b0;
                    state_q    <= RESP;
                end
                RESP: begin
                    if (rsp_ready) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign rsp_valid = (state_q == RESP);
    assign busy      = (state_q != IDLE);
    assign rsp_id    = rsp_id_q;
    assign rsp_data  = rsp_data_q;
    assign rsp_cout  = rsp_cout_q;
    assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_alu8_rr_sched.sv
// Scoreboard bench: stimulus pushes hand-computed responses on grant, a monitor
// pops and compares on every response handshake.
module tb_alu8_rr_sched;
    import alu8_sched_pkg::*;

    localparam int W = 8;

    logic         CLK = 1'b0;
    logic         ASYNCRESETN;
    logic [1:0]   req_valid;
    logic [1:0]   req_ready;
    logic [1:0]   req0_op, req1_op;
    logic [W-1:0] req0_a, req0_b, req0_c;
    logic [W-1:0] req1_a, req1_b, req1_c;
    logic         rsp_valid;
    logic         rsp_ready;
    logic         rsp_id;
    logic [W-1:0] rsp_data;
    logic         rsp_cout;
    logic         rsp_err;
    logic         busy;

    typedef struct {
        logic         id;
        logic [W-1:0] data;
        logic         cout;
        logic         err;
        int           acc_cyc;
        int           lat;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   first_valid = 0;
    logic prev_valid = 1'b0;

    alu8_rr_sched #(
        .W(W)
    ) dut (
        .CLK        (CLK),
        .ASYNCRESETN(ASYNCRESETN),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req0_op    (req0_op),
        .req0_a     (req0_a),
        .req0_b     (req0_b),
        .req0_c     (req0_c),
        .req1_op    (req1_op),
        .req1_a     (req1_a),
        .req1_b     (req1_b),
        .req1_c     (req1_c),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_id     (rsp_id),
        .rsp_data   (rsp_data),
        .rsp_cout   (rsp_cout),
        .rsp_err    (rsp_err),
        .busy       (busy)
    );

    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc = cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    // Monitor: first-valid cycle gives latency relative to the cycle the grant was seen.
    always @(negedge CLK) begin
        exp_t e;
        if (rsp_valid && !prev_valid) first_valid = cyc;
        prev_valid = rsp_valid;
        if (rsp_valid && rsp_ready) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_rsp: got id=%0d data=%0h expected no response",
                         rsp_id, rsp_data);
            end else begin
                e = sb.pop_front();
                chk("rsp_id", 32'(rsp_id), 32'(e.id));
                chk("rsp_data", 32'(rsp_data), 32'(e.data));
                chk("rsp_cout", 32'(rsp_cout), 32'(e.cout));
                chk("rsp_err", 32'(rsp_err), 32'(e.err));
                chk("latency", 32'(first_valid - e.acc_cyc), 32'(e.lat));
            end
        end
    end

    task automatic push(input logic id, input logic [W-1:0] d, input logic co,
                        input logic er, input int lat);
        exp_t e;
        e.id = id; e.data = d; e.cout = co; e.err = er; e.acc_cyc = cyc; e.lat = lat;
        sb.push_back(e);
    endtask

    task automatic drive(input logic id, input logic [1:0] op, input logic [W-1:0] a,
                         input logic [W-1:0] b, input logic [W-1:0] c);
        if (id) begin
            req1_op = op; req1_a = a; req1_b = b; req1_c = c;
        end else begin
            req0_op = op; req0_a = a; req0_b = b; req0_c = c;
        end
    endtask

    task automatic issue(input logic id, input logic [1:0] op, input logic [W-1:0] a,
                         input logic [W-1:0] b, input logic [W-1:0] c,
                         input logic [W-1:0] ed, input logic ec, input logic ee,
                         input int lat);
        bit got = 1'b0;
        @(posedge CLK); #1;
        drive(id, op, a, b, c);
        req_valid[id] = 1'b1;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge CLK);
            if (req_ready[id]) begin
                push(id, ed, ec, ee, lat);
                got = 1'b1;
            end
        end
        if (!got) chk("grant_timeout", 32'(0), 32'(1));
        @(posedge CLK); #1;
        req_valid[id] = 1'b0;
    endtask

    initial begin
        int  k;
        bit  done;
        logic g;
        ASYNCRESETN = 1'b0;
        req_valid = 2'b11;
        rsp_ready = 1'b1;
        drive(1'b0, 2'b00, 8'h10, 8'h20, 8'h00);
        drive(1'b1, 2'b00, 8'hF0, 8'h20, 8'h00);
        #12;
        chk("reset_busy", 32'(busy), 32'(0));
        chk("reset_rsp_valid", 32'(rsp_valid), 32'(0));
        chk("reset_req_ready", 32'(req_ready), 32'(0));
        chk("reset_rsp_data", 32'(rsp_data), 32'(0));
        chk("reset_rsp_flags", 32'({rsp_id, rsp_cout, rsp_err}), 32'(0));
        req_valid = 2'b00;
        #10 ASYNCRESETN = 1'b1;

        // Round-robin with both requesters held valid.
        @(posedge CLK); #1;
        req_valid = 2'b11;
        k = 0;
        for (int i = 0; i < 40 && k < 4; i++) begin
            @(negedge CLK);
            if (req_ready != 2'b00) begin
                chk("rr_onehot", 32'(req_ready == 2'b11), 32'(0));
                g = req_ready[1];
                chk("rr_grant", 32'(g), 32'(k % 2));
                if (g) push(1'b1, 8'h10, 1'b1, 1'b0, 2);
                else push(1'b0, 8'h30, 1'b0, 1'b0, 2);
                k++;
            end
        end
        chk("rr_grant_count", 32'(k), 32'(4));
        @(posedge CLK); #1;
        req_valid = 2'b00;

        issue(1'b0, OP_ADD, 8'hFF, 8'h01, 8'h00, 8'h00, 1'b1, 1'b0, 2);
        issue(1'b1, OP_SUB, 8'h05, 8'h07, 8'h00, 8'hFE, 1'b0, 1'b0, 2);
        issue(1'b1, OP_SUB, 8'h07, 8'h05, 8'h00, 8'h02, 1'b1, 1'b0, 2);
        issue(1'b0, OP_ADDSUB, 8'h03, 8'h04, 8'h03, 8'h04, 1'b1, 1'b0, 3);
        issue(1'b1, OP_RSVD, 8'h55, 8'hAA, 8'h11, 8'h00, 1'b0, 1'b1, 2);

        // Back-pressure: response must hold while no new grants appear.
        for (int i = 0; i < 20 && sb.size() != 0; i++) @(negedge CLK);
        rsp_ready = 1'b0;
        issue(1'b0, OP_ADD, 8'h80, 8'h80, 8'h00, 8'h00, 1'b1, 1'b0, 2);
        done = 1'b0;
        for (int i = 0; i < 20 && !done; i++) begin
            @(negedge CLK);
            done = rsp_valid;
        end
        chk("stall_reached_resp", 32'(done), 32'(1));
        req_valid = 2'b11;
        for (int i = 0; i < 5; i++) begin
            @(negedge CLK);
            chk("stall_valid", 32'(rsp_valid), 32'(1));
            chk("stall_outputs", 32'({rsp_id, rsp_data, rsp_cout, rsp_err}),
                32'({1'b0, 8'h00, 1'b1, 1'b0}));
            chk("stall_req_ready", 32'(req_ready), 32'(0));
        end
        @(posedge CLK); #1;
        req_valid = 2'b00;
        rsp_ready = 1'b1;
        for (int i = 0; i < 20 && sb.size() != 0; i++) @(negedge CLK);

        // Reset during PASS2 of a req0 ADDSUB (which also leaves last_grant at 0).
        @(posedge CLK); #1;
        drive(1'b0, OP_ADDSUB, 8'h01, 8'h02, 8'h03);
        req_valid = 2'b01;
        @(negedge CLK);
        chk("abort_grant", 32'(req_ready), 32'(2'b01));
        @(posedge CLK); #1;
        req_valid = 2'b00;
        @(posedge CLK); #1;
        chk("abort_busy_pre", 32'(busy), 32'(1));
        chk("abort_no_valid_pre", 32'(rsp_valid), 32'(0));
        drive(1'b0, OP_ADD, 8'h10, 8'h20, 8'h00);
        drive(1'b1, OP_ADD, 8'hF0, 8'h20, 8'h00);
        req_valid = 2'b11;
        ASYNCRESETN = 1'b0;
        #1;
        chk("abort_busy", 32'(busy), 32'(0));
        chk("abort_rsp_valid", 32'(rsp_valid), 32'(0));
        chk("abort_req_ready", 32'(req_ready), 32'(0));
        @(posedge CLK);
        @(negedge CLK);
        chk("abort_hold_valid", 32'(rsp_valid), 32'(0));
        ASYNCRESETN = 1'b1;
        #1;
        chk("post_reset_tie", 32'(req_ready), 32'(2'b01));
        if (req_ready == 2'b01) push(1'b0, 8'h30, 1'b0, 1'b0, 2);
        @(posedge CLK); #1;
        req_valid = 2'b00;

        for (int i = 0; i < 50 && sb.size() != 0; i++) @(negedge CLK);
        chk("scoreboard_drained", 32'(sb.size()), 32'(0));
        repeat (3) @(negedge CLK);
        chk("final_idle", 32'(busy), 32'(0));
        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end

endmodule
